// File: rtl/vc_elastic_pipe_stage.sv
// One slot of the elastic pipeline: a valid bit plus a data register.
// Data only loads on a real message so bubbles never toggle the data path.
module vc_elastic_pipe_stage #(
    parameter int                 p_nbits       = 32,
    parameter logic [p_nbits-1:0] p_reset_value = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               load,
    input  logic               in_val,
    input  logic [p_nbits-1:0] in_msg,
    output logic               val,
    output logic [p_nbits-1:0] msg
);

    // Flush drops the valid bit but leaves the data register untouched.
    always_ff @(posedge clk) begin
        if (!reset) begin
            val <= 1'b0;
            msg <= p_reset_value;
        end else begin
            if (flush) begin
                val <= 1'b0;
            end else if (load) begin
                val <= in_val;
            end
            if (load && in_val && !flush) begin
                msg <= in_msg;
            end
        end
    end

endmodule

// File: rtl/vc_elastic_pipe_reg.sv
// Multi-stage elastic pipeline register with val/rdy on both sides,
// bubble collapsing, synchronous flush and a registered occupancy count.
module vc_elastic_pipe_reg #(
    parameter int                 p_nbits       = 32,
    parameter int                 p_nstages     = 2,
    parameter logic [p_nbits-1:0] p_reset_value = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               enq_val,
    output logic                               enq_rdy,
    input  logic [p_nbits-1:0]                 enq_msg,
    output logic                               deq_val,
    input  logic                               deq_rdy,
    output logic [p_nbits-1:0]                 deq_msg,
    output logic [$clog2(p_nstages+1)-1:0]     count
);

    localparam int c_count_nbits = $clog2(p_nstages + 1);

    logic [p_nstages-1:0] val;
    logic [p_nstages-1:0] rdy;
    logic [p_nstages-1:0] in_val;
    logic [p_nbits-1:0]   in_msg [p_nstages];
    logic [p_nbits-1:0]   data   [p_nstages];
    logic                 enq_fire;
    logic                 deq_fire;

    // A stage is ready when it or any stage downstream of it has a hole,
    // which is the unrolled form of rdy[i] = !val[i] || rdy[i+1].
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        rdy      = '0;
        for (int i = p_nstages - 1; i >= 0; i--) begin
            all_full = all_full & val[i];
            rdy[i]   = deq_rdy | ~all_full;
        end
    end

    assign enq_rdy  = rdy[0] && !flush && reset;
    assign enq_fire = enq_val && enq_rdy;
    assign deq_fire = deq_val && deq_rdy;
    assign deq_val  = val[p_nstages-1];
    assign deq_msg  = data[p_nstages-1];

    for (genvar i = 0; i < p_nstages; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign in_val[i] = enq_fire;
            assign in_msg[i] = enq_msg;
        end else begin : g_body
            assign in_val[i] = val[i-1];
            assign in_msg[i] = data[i-1];
        end

        vc_elastic_pipe_stage #(
            .p_nbits       (p_nbits),
            .p_reset_value (p_reset_value)
        ) u_stage (
            .clk    (clk),
            .reset  (reset),
            .flush  (flush),
            .load   (rdy[i]),
            .in_val (in_val[i]),
            .in_msg (in_msg[i]),
            .val    (val[i]),
            .msg    (data[i])
        );
    end

    // A deq in the flush cycle is still delivered; the count simply restarts at 0.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            count <= '0;
        end else begin
            count <= count + c_count_nbits'(enq_fire) - c_count_nbits'(deq_fire);
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            assert (!$isunknown(enq_val));
            assert (!$isunknown(deq_rdy));
            assert (int'(count) == $countones(val));
        end
    end

endmodule

// File: tb/tb_vc_elastic_pipe_reg.sv
// Directed scoreboard bench for vc_elastic_pipe_reg: a 3-stage 8-bit instance
// and a degenerate 1-stage instance.
module tb_vc_elastic_pipe_reg;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       enq_val;
    logic       enq_rdy;
    logic [7:0] enq_msg;
    logic       deq_val;
    logic       deq_rdy;
    logic [7:0] deq_msg;
    logic [1:0] count;

    logic       enq_val1;
    logic       enq_rdy1;
    logic [7:0] enq_msg1;
    logic       deq_val1;
    logic       deq_rdy1;
    logic [7:0] deq_msg1;
    logic [0:0] count1;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    bit latChk   = 0;

    logic [7:0] q[$];
    int         qc[$];
    logic [7:0] q1[$];

    vc_elastic_pipe_reg #(
        .p_nbits       (8),
        .p_nstages     (3),
        .p_reset_value (8'h5A)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .enq_val (enq_val),
        .enq_rdy (enq_rdy),
        .enq_msg (enq_msg),
        .deq_val (deq_val),
        .deq_rdy (deq_rdy),
        .deq_msg (deq_msg),
        .count   (count)
    );

    vc_elastic_pipe_reg #(
        .p_nbits       (8),
        .p_nstages     (1),
        .p_reset_value (8'h00)
    ) dut1 (
        .clk     (clk),
        .reset   (reset),
        .flush   (1'b0),
        .enq_val (enq_val1),
        .enq_rdy (enq_rdy1),
        .enq_msg (enq_msg1),
        .deq_val (deq_val1),
        .deq_rdy (deq_rdy1),
        .deq_msg (deq_msg1),
        .count   (count1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle on the 3-stage instance: drive, sample at the falling edge, score, clock.
    // expDv < 0 means deq_val is not checked directly this cycle.
    task automatic applyStimulus(input logic ev, input logic [7:0] em, input logic dr,
                                 input logic fl, input logic rs, input int expDv);
        logic expRdy;
        enq_val = ev;
        enq_msg = em;
        deq_rdy = dr;
        flush   = fl;
        reset   = rs;
        #4;
        expRdy = rs && !fl && (q.size() < 3 || dr);
        checkOutput("enq_rdy", {31'd0, enq_rdy}, {31'd0, expRdy});
        checkOutput("count", {30'd0, count}, q.size());
        if (expDv >= 0) begin
            checkOutput("deq_val", {31'd0, deq_val}, expDv);
        end
        if (rs && deq_val && dr) begin
            if (q.size() == 0) begin
                checkOutput("deq_unexpected", {31'd0, deq_val}, 32'd0);
            end else begin
                checkOutput("deq_msg", {24'd0, deq_msg}, {24'd0, q.pop_front()});
                if (latChk) begin
                    checkOutput("latency", cycle - qc[0], 32'd3);
                end
                void'(qc.pop_front());
            end
        end
        if (ev && expRdy) begin
            q.push_back(em);
            qc.push_back(cycle);
        end
        if (!rs || fl) begin
            q.delete();
            qc.delete();
        end
        cycle++;
        @(posedge clk);
        #1;
    endtask

    // Same idea for the single-stage instance; every delivery must be one cycle after its enq.
    task automatic applyStimulus1(input logic ev, input logic [7:0] em, input logic dr, input int expDv);
        logic expRdy;
        enq_val  = 1'b0;
        deq_rdy  = 1'b0;
        flush    = 1'b0;
        reset    = 1'b1;
        enq_val1 = ev;
        enq_msg1 = em;
        deq_rdy1 = dr;
        #4;
        expRdy = (q1.size() < 1) || dr;
        checkOutput("enq_rdy1", {31'd0, enq_rdy1}, {31'd0, expRdy});
        checkOutput("count1", {31'd0, count1}, q1.size());
        checkOutput("deq_val1", {31'd0, deq_val1}, expDv);
        if (deq_val1 && dr) begin
            if (q1.size() == 0) begin
                checkOutput("deq1_unexpected", {31'd0, deq_val1}, 32'd0);
            end else begin
                checkOutput("deq_msg1", {24'd0, deq_msg1}, {24'd0, q1.pop_front()});
            end
        end
        if (ev && expRdy) begin
            q1.push_back(em);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        flush    = 1'b0;
        enq_val  = 1'b0;
        enq_msg  = 8'h00;
        deq_rdy  = 1'b0;
        enq_val1 = 1'b0;
        enq_msg1 = 8'h00;
        deq_rdy1 = 1'b0;
        @(posedge clk);
        #1;

        // Reset state.
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        checkOutput("rst_deq_msg", {24'd0, deq_msg}, 32'h5A);
        checkOutput("rst_count", {30'd0, count}, 32'd0);

        // Streaming with deq_rdy held high.
        latChk = 1;
        applyStimulus(1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 0);
        applyStimulus(1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 0);
        applyStimulus(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0);

        // Backpressure: fill, reject a 4th, then drain.
        latChk = 0;
        applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 0);
        applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 0);
        applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 0);
        applyStimulus(1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0);

        // Bubble collapse behind a stalled output.
        applyStimulus(1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0);
        applyStimulus(1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0);

        // Flush coinciding with a deq and an attempted enq.
        applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 0);
        applyStimulus(1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 0);
        applyStimulus(1'b1, 8'hB3, 1'b0, 1'b0, 1'b1, 0);
        applyStimulus(1'b1, 8'hC0, 1'b1, 1'b1, 1'b1, 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0);

        // Reset with messages in flight, then a clean message afterwards.
        applyStimulus(1'b1, 8'h61, 1'b0, 1'b0, 1'b1, 0);
        applyStimulus(1'b1, 8'h62, 1'b0, 1'b0, 1'b1, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, -1);
        checkOutput("mid_rst_deq_val", {31'd0, deq_val}, 32'd0);
        checkOutput("mid_rst_deq_msg", {24'd0, deq_msg}, 32'h5A);
        checkOutput("mid_rst_count", {30'd0, count}, 32'd0);
        latChk = 1;
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0);

        // Single-stage instance.
        applyStimulus1(1'b1, 8'h01, 1'b1, 0);
        applyStimulus1(1'b1, 8'h02, 1'b1, 1);
        applyStimulus1(1'b0, 8'h00, 1'b1, 1);
        applyStimulus1(1'b1, 8'h03, 1'b0, 0);
        applyStimulus1(1'b1, 8'h04, 1'b0, 1);
        applyStimulus1(1'b0, 8'h00, 1'b1, 1);
        applyStimulus1(1'b0, 8'h00, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vc_elastic_pipe_reg.md
Name: vc_elastic_pipe_reg

Overview:
- Parametrised multi-stage pipeline register with val/rdy handshake on both sides.
- Each stage holds one message plus a valid bit. Bubbles collapse: a stalled output lets upstream stages fill their empty slots.
- Supports a synchronous flush and reports an occupancy count.
- Drop-in replacement wherever a chain of enable/reset registers carries a message between val/rdy interfaces, such as processor pipeline latches and memory response paths.

Parameters:
- p_nbits, 32, message width in bits (>=1).
- p_nstages, 2, number of register stages (>=1). Also the minimum enq-to-deq latency in cycles.
- p_reset_value, 0, value loaded into every stage data register on reset.

Ports:
- clk  input  1  clock. All state updates on the posedge.
- reset  input  1  synchronous, active-low reset. reset==0 at a posedge resets all state.
- flush  input  1  synchronous clear of all valid bits.
- enq_val  input  1  upstream message valid.
- enq_rdy  output  1  block can accept a message this cycle.
- enq_msg  input  p_nbits  upstream message.
- deq_val  output  1  the last stage holds a valid message.
- deq_rdy  input  1  downstream accepts this cycle.
- deq_msg  output  p_nbits  last-stage message.
- count  output  $clog2(p_nstages+1)  number of valid stages.

Behaviour:
- Stage indexing: stage 0 is nearest enq; stage p_nstages-1 drives deq.
- Outputs: deq_val = val[N-1]; deq_msg = data[N-1].
- Ready chain, purely combinational:
  - rdy[N] = deq_rdy.
  - rdy[i] = !val[i] || rdy[i+1].
  - enq_rdy = rdy[0] && !flush && reset.
- Stage inputs: in_val[0] = enq_val && enq_rdy; in_val[i] = val[i-1] for i>0. in_msg follows the same pattern.
- Stage update at posedge when rdy[i]==1:
  - val[i] <= in_val[i].
  - data[i] loads in_msg only when in_val[i]==1. Otherwise data holds (no toggling on bubbles).
- Stage update when rdy[i]==0: val[i] and data[i] both hold.
- Transfers: an enq transfer is enq_val&&enq_rdy; a deq transfer is deq_val&&deq_rdy.
- Throughput: 1 message/cycle when deq_rdy is held high.
- Latency: exactly p_nstages cycles from enq transfer to deq_val when no stall occurs. Message order is strictly preserved.
- No combinational path from enq_msg or enq_val to the deq side.
- The only combinational path is deq_rdy -> enq_rdy, through the ready chain.
- Full (all val==1) with deq_rdy==0: enq_rdy=0 and all stages hold.
- Full with deq_rdy==1: the whole chain advances and enq_rdy=1.
- Empty: deq_val=0. A message entering stage 0 advances one stage per cycle.
- Stalled output: upstream messages advance into empty stages until contiguous behind stage N-1.
- flush==1 at a posedge:
  - All val <= 0 and count <= 0. Data registers hold.
  - A deq transfer in the same cycle still counts as delivered.
  - enq_rdy is forced to 0, so no enq occurs.
- reset==0 at a posedge:
  - Overrides flush and the handshake.
  - All val <= 0, all data <= p_reset_value, count <= 0.
  - enq_rdy=0 while reset==0.
- Reset mid-operation discards in-flight messages. The first cycle after deassertion is identical to post-reset.
- count is registered and tracks the number of set val bits.
  - Update rule: count <= count + enq_fire - deq_fire, or 0 on flush/reset.
  - count never exceeds p_nstages.
- Reset values: deq_val=0, deq_msg=p_reset_value, count=0, enq_rdy=0 during reset and =1 after.
- p_nstages==1 degenerates to a single full-throughput pipeline register with a combinational rdy pass-through.
- Simulation assertions, only when reset==1:
  - enq_val not X.
  - deq_rdy not X.
  - count == popcount(val).

Decomposition:
- No shared package is needed. The count width is a localparam computed in the module.
- One sub-module, vc_elastic_pipe_stage. It holds one stage's val bit and data register, with inputs in_val, in_msg, load(=rdy[i]), flush, reset.
- The top level instantiates p_nstages of these in a generate loop, builds the ready chain, and maintains count.

Test Plan:
- Streaming, p_nbits=8, p_nstages=3, deq_rdy=1: enq 0x11, 0x22, 0x33 on back-to-back cycles -> deq_msg 0x11, 0x22, 0x33 appear on cycles 3, 4, 5 after the first enq; count peaks at 3; enq_rdy stays 1.
- Backpressure: fill with 0xA1..0xA3 while deq_rdy=0 -> count=3, enq_rdy=0, and a 4th enq 0xA4 is not accepted; raise deq_rdy for 3 cycles -> 0xA1, 0xA2, 0xA3 delivered in order and count returns to 0.
- Bubble collapse: enq 0x05, idle 1 cycle, enq 0x06, deq_rdy=0 -> after 4 cycles stages 2 and 1 hold 0x05 and 0x06 and count=2; deq then yields 0x05 followed by 0x06 on consecutive cycles.
- Flush with deq: full chain holding 0xB1..0xB3, deq_rdy=1 and flush=1 in the same cycle -> 0xB1 is delivered; next cycle deq_val=0 and count=0; an enq_val=1 during the flush cycle is not accepted.
- Reset mid-operation: 2 messages in flight, p_reset_value=0x5A, reset=0 for 1 cycle -> deq_val=0, deq_msg=0x5A, count=0; a new enq 0x77 afterwards emerges after exactly 3 cycles.
- Degenerate p_nstages=1: enq 0x01 and 0x02 on consecutive cycles with deq_rdy=1 -> each emerges 1 cycle later; with deq_rdy=0 and the stage full, enq_rdy=0.
